// File: rtl/counter.sv
// counter: wrapping up counter INIT..MAX by STEP; ports: out (count register), clk (rising edge), reset (async, active-low)
module counter #(
    parameter int    WIDTH = 8,
    parameter longint INIT = 0,
    parameter longint STEP = 1,
    parameter longint MAX  = (64'd1 << WIDTH) - 1
) (
    output logic [WIDTH-1:0] out,
    input  logic             clk,
    input  logic             reset
);
    localparam longint FULL = (64'd1 << WIDTH) - 1;
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("counter: WIDTH must be 1..32");
    end
    if (MAX > FULL || INIT > MAX) begin : g_bad_range
        $error("counter: need INIT <= MAX <= 2**WIDTH-1");
    end
    if (STEP < 1 || STEP > MAX) begin : g_bad_step
        $error("counter: STEP must be 1..MAX");
    end
    localparam logic [63:0] INIT_V = 64'(INIT);
    localparam logic [63:0] STEP_V = 64'(STEP);
    localparam logic [63:0] MAX_V  = 64'(MAX);
    localparam logic [WIDTH:0] init_w = INIT_V[WIDTH:0];
    localparam logic [WIDTH:0] step_w = STEP_V[WIDTH:0];
    localparam logic [WIDTH:0] max_w  = MAX_V[WIDTH:0];
    logic [WIDTH:0] sum;
    logic [WIDTH:0] nxt;
    always_comb begin
        sum = {1'b0, out} + step_w;
        nxt = (sum <= max_w) ? sum : init_w + (sum - max_w - 1'b1);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) out <= init_w[WIDTH-1:0];
        else        out <= nxt[WIDTH-1:0];
    end
endmodule

// File: tb/tb_counter.sv
// tb_counter: directed checks of counter with default and custom parameters
module tb_counter;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       reset2 = 1'b0;
    logic [7:0] out;
    logic [3:0] out2;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         exp2 [9] = '{5, 8, 3, 6, 9, 4, 7, 2, 5};

    counter dut (.out(out), .clk(clk), .reset(reset));
    counter #(.WIDTH(4), .INIT(2), .STEP(3), .MAX(9)) dut2 (.out(out2), .clk(clk), .reset(reset2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        repeat (2) begin
            @(negedge clk);
            chk("reset_hold", 32'(out), 0);
        end
        reset = 1'b1;
        for (int k = 1; k <= 257; k++) begin
            @(negedge clk);
            chk("count_wrap", 32'(out), k % 256);
        end
        repeat (36) @(negedge clk);
        chk("reach_37", 32'(out), 37);
        #2 reset = 1'b0;
        #1 chk("async_reset", 32'(out), 0);
        repeat (3) begin
            @(negedge clk);
            chk("held_low", 32'(out), 0);
        end
        reset = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("resume", 32'(out), k);
        end
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("edge_release_0", 32'(out), 0);
        @(negedge clk);
        chk("edge_release_1", 32'(out), 1);
        #3 reset = 1'b0;
        #1 chk("pulse1_low", 32'(out), 0);
        #10 reset = 1'b1;
        @(negedge clk);
        chk("pulse1_resume1", 32'(out), 1);
        @(negedge clk);
        chk("pulse1_resume2", 32'(out), 2);
        #7 reset = 1'b0;
        #1 chk("pulse2_low", 32'(out), 0);
        #10 reset = 1'b1;
        @(negedge clk);
        chk("pulse2_pre", 32'(out), 0);
        @(negedge clk);
        chk("pulse2_resume1", 32'(out), 1);
        @(negedge clk);
        chk("pulse2_resume2", 32'(out), 2);
        chk("p2_reset", 32'(out2), 2);
        reset2 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("p2_seq", 32'(out2), exp2[i]);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter WIDTH, default 8: counter and output width in bits, legal range 1..32.
REQ-002 Parameter INIT, default 0: value loaded on reset and after wrap, in range 0..MAX.
REQ-003 Parameter STEP, default 1: increment per enabled clock edge, in range 1..MAX.
REQ-004 Parameter MAX, default 2**WIDTH-1: terminal count, with INIT <= MAX <= 2**WIDTH-1.
REQ-005 Port order SHALL be out, clk, reset; this order is fixed for positional instantiation.
REQ-006 clk  input  1  the single clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset; low forces reset state immediately.
REQ-008 out  output  WIDTH  current count, driven directly from a register.

Function
REQ-009 The design SHALL contain one WIDTH-bit count register; out SHALL equal it, with no combinational path from any input to out.
REQ-010 While reset=1, each rising clk edge SHALL update count: if count+STEP <= MAX then count+STEP, else INIT+(count+STEP-MAX-1) (modular wrap into INIT..MAX).
REQ-011 Wrap arithmetic SHALL be computed at WIDTH+1 bits so that no intermediate overflow occurs; with defaults, 8'hFF SHALL be followed by 8'h00.
REQ-012 Latency SHALL be exactly one clock: a value written at edge N is visible on out after edge N, before edge N+1.
REQ-013 There SHALL be no enable or hold condition; the counter advances on every rising clk edge while reset is deasserted.
REQ-014 The count SHALL never hold a value outside INIT..MAX after the first clock following reset.
REQ-015 With default parameters, out SHALL be a free-running 8-bit up counter, 0,1,2,...,255,0,....

Reset
REQ-016 When reset goes low, out SHALL become INIT immediately, asynchronously, without waiting for clk.
REQ-017 While reset is held low, out SHALL remain INIT regardless of clk activity.
REQ-018 On the first rising clk edge with reset=1 after release, count SHALL become INIT+STEP (wrapped per REQ-010).
REQ-019 If a rising clk edge coincides with reset deassertion, the edge SHALL be ignored and out SHALL stay INIT until the next edge.
REQ-020 Reset asserted mid-count SHALL discard the current value; no partial or delayed update SHALL follow.
REQ-021 Out-of-range parameter combinations SHALL be rejected at elaboration with an error.

Verification
REQ-022 Defaults; reset low at t=0 for 2 clocks, then released; run 10 clocks -> out 0 during reset, then 1..10 on successive edges.
REQ-023 Defaults; run 256 clocks from reset -> out 255 after edge 255, out 0 after edge 256, out 1 after edge 257.
REQ-024 Defaults; count reaches 37; drive reset low mid-cycle, between edges -> out becomes 0 before the next edge; hold low for 3 edges -> stays 0; release -> 1, 2, ....
REQ-025 Defaults; release reset coincident with a clk edge -> out 0 after that edge, 1 after the following edge.
REQ-026 Set WIDTH=4, INIT=2, STEP=3, MAX=9; reset then run -> sequence 2, 5, 8, 3, 6, 9, 4, 7, 2, ...; out never exceeds 9.
REQ-027 Pulse reset twice, 11 time units each, at arbitrary phases during a 300-unit run -> out returns to 0 on each pulse and resumes counting from 1.
